// File: rtl/tqvp_dlmiles_i2c_xfifo.sv
// TX/RX byte buffering between the CPU DATA register and the I2C byte FSM.
// Two first-word-fall-through FIFOs with level counters, watermarks, flush and sticky overrun.
module tqvp_dlmiles_i2c_xfifo #(
    parameter  int DATA_W   = 8,
    parameter  int TX_DEPTH = 4,
    parameter  int RX_DEPTH = 4,
    localparam int TLW      = $clog2(TX_DEPTH) + 1,
    localparam int RLW      = $clog2(RX_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_flush_i,
    input  logic              rx_flush_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W:0]   wr_data_i,
    output logic [DATA_W:0]   txd_data_o,
    output logic              txd_valid_o,
    input  logic              txd_ready_i,
    input  logic [DATA_W-1:0] rxd_data_i,
    input  logic              rxd_valid_i,
    input  logic              rd_stb_i,
    output logic [DATA_W:0]   rd_data_o,
    output logic [TLW-1:0]    tx_level_o,
    output logic [RLW-1:0]    rx_level_o,
    input  logic [TLW-1:0]    tx_thresh_i,
    input  logic [RLW-1:0]    rx_thresh_i,
    output logic              tx_low_o,
    output logic              rx_high_o,
    output logic              st_tx_full_o,
    output logic              st_tx_empty_o,
    output logic              st_rx_full_o,
    output logic              st_rx_empty_o,
    output logic              st_tx_overrun_o,
    output logic              st_rx_overrun_o
);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int RPW = $clog2(RX_DEPTH);

    logic [DATA_W:0]   tx_mem_q [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];

    logic [TPW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TLW-1:0] tx_level_q, tx_level_d;
    logic           tx_ovr_q, tx_ovr_d;
    logic [RPW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RLW-1:0] rx_level_q, rx_level_d;
    logic           rx_ovr_q, rx_ovr_d;

    logic tx_full, tx_empty, tx_push, tx_pop, tx_we;
    logic rx_full, rx_empty, rx_push, rx_pop, rx_we;

    // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
    always_comb begin
        tx_full   = (tx_level_q == TLW'(TX_DEPTH));
        tx_empty  = (tx_level_q == '0);
        tx_pop    = ~tx_empty & txd_ready_i;
        tx_push   = wr_valid_i & (~tx_full | tx_pop);
        tx_we     = tx_push & ~tx_flush_i;
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_level_d = tx_level_q;
        tx_ovr_d   = tx_ovr_q;
        if (tx_flush_i) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_level_d = '0;
            tx_ovr_d   = 1'b0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + TPW'(1);
            if (tx_pop)  tx_rptr_d = tx_rptr_q + TPW'(1);
            if (tx_push && !tx_pop)      tx_level_d = tx_level_q + TLW'(1);
            else if (tx_pop && !tx_push) tx_level_d = tx_level_q - TLW'(1);
            if (wr_valid_i && tx_full && !tx_pop) tx_ovr_d = 1'b1;
        end
    end

    // An empty RX FIFO ignores the pop strobe, so push-into-empty is never blocked.
    always_comb begin
        rx_full   = (rx_level_q == RLW'(RX_DEPTH));
        rx_empty  = (rx_level_q == '0);
        rx_pop    = rd_stb_i & ~rx_empty;
        rx_push   = rxd_valid_i & (~rx_full | rx_pop);
        rx_we     = rx_push & ~rx_flush_i;
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_level_d = rx_level_q;
        rx_ovr_d   = rx_ovr_q;
        if (rx_flush_i) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_level_d = '0;
            rx_ovr_d   = 1'b0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + RPW'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + RPW'(1);
            if (rx_push && !rx_pop)      rx_level_d = rx_level_q + RLW'(1);
            else if (rx_pop && !rx_push) rx_level_d = rx_level_q - RLW'(1);
            if (rxd_valid_i && rx_full && !rx_pop) rx_ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
            tx_ovr_q   <= 1'b0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            rx_ovr_q   <= 1'b0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_level_q <= tx_level_d;
            tx_ovr_q   <= tx_ovr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_level_q <= rx_level_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    // Storage needs no reset: it is only visible through a non-zero level.
    always_ff @(posedge clk) begin
        if (tx_we) tx_mem_q[tx_wptr_q] <= wr_data_i;
        if (rx_we) rx_mem_q[rx_wptr_q] <= rxd_data_i;
    end

    always_comb begin
        txd_data_o      = tx_mem_q[tx_rptr_q];
        txd_valid_o     = ~tx_empty;
        rd_data_o       = {rx_empty, (rx_empty ? {DATA_W{1'b0}} : rx_mem_q[rx_rptr_q])};
        tx_level_o      = tx_level_q;
        rx_level_o      = rx_level_q;
        tx_low_o        = (tx_level_q <= tx_thresh_i);
        rx_high_o       = (rx_thresh_i != '0) && (rx_level_q >= rx_thresh_i);
        st_tx_full_o    = tx_full;
        st_tx_empty_o   = tx_empty;
        st_rx_full_o    = rx_full;
        st_rx_empty_o   = rx_empty;
        st_tx_overrun_o = tx_ovr_q;
        st_rx_overrun_o = rx_ovr_q;
    end

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_xfifo.sv
// Directed bench for tqvp_dlmiles_i2c_xfifo (DATA_W=8, depths 4) with hand-computed expectations.
module tb_tqvp_dlmiles_i2c_xfifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       tx_flush_i, rx_flush_i;
    logic       wr_valid_i;
    logic [8:0] wr_data_i;
    logic [8:0] txd_data_o;
    logic       txd_valid_o;
    logic       txd_ready_i;
    logic [7:0] rxd_data_i;
    logic       rxd_valid_i;
    logic       rd_stb_i;
    logic [8:0] rd_data_o;
    logic [2:0] tx_level_o, rx_level_o;
    logic [2:0] tx_thresh_i, rx_thresh_i;
    logic       tx_low_o, rx_high_o;
    logic       st_tx_full_o, st_tx_empty_o, st_rx_full_o, st_rx_empty_o;
    logic       st_tx_overrun_o, st_rx_overrun_o;

    int checks = 0;
    int errors = 0;

    tqvp_dlmiles_i2c_xfifo #(.DATA_W(8), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .tx_flush_i(tx_flush_i), .rx_flush_i(rx_flush_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
        .txd_data_o(txd_data_o), .txd_valid_o(txd_valid_o), .txd_ready_i(txd_ready_i),
        .rxd_data_i(rxd_data_i), .rxd_valid_i(rxd_valid_i),
        .rd_stb_i(rd_stb_i), .rd_data_o(rd_data_o),
        .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
        .tx_thresh_i(tx_thresh_i), .rx_thresh_i(rx_thresh_i),
        .tx_low_o(tx_low_o), .rx_high_o(rx_high_o),
        .st_tx_full_o(st_tx_full_o), .st_tx_empty_o(st_tx_empty_o),
        .st_rx_full_o(st_rx_full_o), .st_rx_empty_o(st_rx_empty_o),
        .st_tx_overrun_o(st_tx_overrun_o), .st_rx_overrun_o(st_rx_overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tx_level"}, tx_level_o, 0);
        chk({tag, "_rx_level"}, rx_level_o, 0);
        chk({tag, "_txd_valid"}, txd_valid_o, 0);
        chk({tag, "_rd_data"}, rd_data_o, 9'h100);
        chk({tag, "_tx_low"}, tx_low_o, 1);
        chk({tag, "_rx_high"}, rx_high_o, 0);
        chk({tag, "_flags"}, {st_tx_full_o, st_tx_empty_o, st_rx_full_o, st_rx_empty_o,
                              st_tx_overrun_o, st_rx_overrun_o}, 6'b010100);
    endtask

    logic [8:0] tx_vec [4];

    initial begin
        tx_vec[0] = 9'h0A1; tx_vec[1] = 9'h0B2; tx_vec[2] = 9'h1C3; tx_vec[3] = 9'h0D4;
        rst = 1'b1; tx_flush_i = 0; rx_flush_i = 0; wr_valid_i = 0; wr_data_i = 0;
        txd_ready_i = 0; rxd_data_i = 0; rxd_valid_i = 0; rd_stb_i = 0;
        tx_thresh_i = 0; rx_thresh_i = 0;
        step(); step();
        rst = 1'b0;
        step();
        chk_reset_state("reset");

        // Fill TX to full with a low watermark of 2, then overflow once
        tx_thresh_i = 3'd2;
        for (int i = 0; i < 4; i++) begin
            wr_valid_i = 1; wr_data_i = tx_vec[i];
            step();
            $display("tx push %03h level=%0d low=%0d", tx_vec[i], tx_level_o, tx_low_o);
            if (i == 1) chk("tx_low_at_2", tx_low_o, 1);
            if (i == 2) chk("tx_low_at_3", tx_low_o, 0);
        end
        chk("tx_head_after_fill", txd_data_o, 9'h0A1);
        wr_data_i = 9'h0EE;
        step();
        wr_valid_i = 0;
        $display("tx push 0ee while full level=%0d ovr=%0d", tx_level_o, st_tx_overrun_o);
        chk("tx_full", st_tx_full_o, 1);
        chk("tx_overrun", st_tx_overrun_o, 1);
        chk("tx_level_full", tx_level_o, 4);
        tx_thresh_i = 0;

        txd_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            $display("tx pop %03h valid=%0d", txd_data_o, txd_valid_o);
            chk($sformatf("tx_drain_data%0d", i), txd_data_o, tx_vec[i]);
            chk($sformatf("tx_drain_valid%0d", i), txd_valid_o, 1);
            step();
        end
        txd_ready_i = 0;
        chk("tx_drained_valid", txd_valid_o, 0);
        chk("tx_drained_level", tx_level_o, 0);
        chk("tx_overrun_sticky", st_tx_overrun_o, 1);

        // Refill, then flush together with a push while full and overrun
        for (int i = 0; i < 5; i++) begin
            wr_valid_i = 1; wr_data_i = 9'(9'h020 + i);
            step();
        end
        chk("tx_refill_full", st_tx_full_o, 1);
        tx_flush_i = 1; wr_data_i = 9'h055;
        step();
        tx_flush_i = 0; wr_valid_i = 0;
        $display("tx flush level=%0d empty=%0d ovr=%0d", tx_level_o, st_tx_empty_o, st_tx_overrun_o);
        chk("flush_level", tx_level_o, 0);
        chk("flush_empty", st_tx_empty_o, 1);
        chk("flush_overrun", st_tx_overrun_o, 0);
        chk("flush_valid", txd_valid_o, 0);

        // Full FIFO with push and pop each cycle across pointer wrap
        for (int i = 0; i < 4; i++) begin
            wr_valid_i = 1; wr_data_i = 9'(i + 1);
            step();
        end
        txd_ready_i = 1;
        for (int i = 0; i < 10; i++) begin
            wr_data_i = 9'(9'h010 + i);
            chk($sformatf("wrap_head%0d", i), txd_data_o, (i < 4) ? (i + 1) : (9'h010 + i - 4));
            step();
            $display("tx push %03h + pop, level=%0d", 9'(9'h010 + i), tx_level_o);
            chk($sformatf("wrap_level%0d", i), tx_level_o, 4);
        end
        wr_valid_i = 0;
        chk("wrap_no_overrun", st_tx_overrun_o, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_tail%0d", i), txd_data_o, 9'h016 + i);
            step();
        end
        txd_ready_i = 0;
        chk("wrap_empty", st_tx_empty_o, 1);

        // RX watermark and pop ordering
        rx_thresh_i = 3'd3;
        for (int i = 0; i < 3; i++) begin
            rxd_valid_i = 1; rxd_data_i = 8'(8'h11 * (i + 1));
            step();
            $display("rx push %02h level=%0d high=%0d", rxd_data_i, rx_level_o, rx_high_o);
            if (i == 1) chk("rx_high_at_2", rx_high_o, 0);
        end
        rxd_valid_i = 0;
        chk("rx_high_at_3", rx_high_o, 1);
        chk("rx_head_11", rd_data_o, 9'h011);
        rd_stb_i = 1;
        step();
        $display("rx pop -> rd_data=%03h level=%0d", rd_data_o, rx_level_o);
        chk("rx_high_fall", rx_high_o, 0);
        chk("rx_level_2", rx_level_o, 2);
        chk("rx_head_22", rd_data_o, 9'h022);
        step();
        chk("rx_head_33", rd_data_o, 9'h033);
        step();
        chk("rx_empty_data", rd_data_o, 9'h100);
        step();
        rd_stb_i = 0;
        chk("rx_pop_empty_level", rx_level_o, 0);
        chk("rx_pop_empty_ovr", st_rx_overrun_o, 0);

        // RX overflow keeps existing contents, then flush
        for (int i = 0; i < 5; i++) begin
            rxd_valid_i = 1; rxd_data_i = 8'(8'h41 + i);
            step();
        end
        rxd_valid_i = 0;
        $display("rx overflow level=%0d ovr=%0d head=%03h", rx_level_o, st_rx_overrun_o, rd_data_o);
        chk("rx_full", st_rx_full_o, 1);
        chk("rx_overrun", st_rx_overrun_o, 1);
        chk("rx_head_kept", rd_data_o, 9'h041);
        rx_flush_i = 1;
        step();
        rx_flush_i = 0;
        chk("rx_flush_level", rx_level_o, 0);
        chk("rx_flush_ovr", st_rx_overrun_o, 0);
        chk("rx_flush_data", rd_data_o, 9'h100);
        rx_thresh_i = 0;

        // Reset with both FIFOs half full and all strobes active
        for (int i = 0; i < 2; i++) begin
            wr_valid_i = 1; wr_data_i = 9'(9'h0A0 + i);
            rxd_valid_i = 1; rxd_data_i = 8'(8'h50 + i);
            step();
        end
        chk("half_tx_level", tx_level_o, 2);
        chk("half_rx_level", rx_level_o, 2);
        rst = 1; txd_ready_i = 1; rd_stb_i = 1;
        step();
        rst = 0; wr_valid_i = 0; rxd_valid_i = 0; txd_ready_i = 0; rd_stb_i = 0;
        $display("mid-op reset tx_level=%0d rx_level=%0d rd_data=%03h", tx_level_o, rx_level_o, rd_data_o);
        chk_reset_state("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
